// File: rtl/irq_vec_ctrl.sv
// Vectored interrupt controller: latches and masks N_SRC request lines, picks the
// highest-priority eligible source, handshakes with the CPU and tracks in-service levels.
//
// state | meaning
// IDLE  | no request presented to the control unit
// REQ   | INT_irq asserted, selection re-evaluated every cycle
// SERV  | acknowledge taken; vector/isr updated on entry, returns to IDLE
module irq_vec_ctrl #(
    parameter int                 N_SRC      = 8,
    parameter logic [N_SRC-1:0]   EDGE_MASK  = {N_SRC{1'b1}},
    parameter bit                 NEST_EN    = 1'b1,
    parameter logic [31:0]        VEC_BASE   = 32'h0000_0018,
    parameter int                 VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             INTA_irq,
    input  logic             eoi,
    output logic             INT_irq,
    output logic [31:0]      vector,
    output logic             vec_valid,
    output logic [N_SRC-1:0] pend,
    output logic [N_SRC-1:0] isr
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [N_SRC-1:0]   mask;
    logic [N_SRC-1:0]   hist;
    logic [N_SRC-1:0]   req;
    logic               cand_hit, isr_hit;
    logic [IDX_W-1:0]   cand_idx, isr_idx;
    logic               eligible;
    logic               ack;
    logic [N_SRC-1:0]   ack_oh;
    logic [N_SRC-1:0]   eoi_clr;
    logic [N_SRC-1:0]   pend_edge;
    logic [N_SRC-1:0]   pend_d;
    logic [N_SRC-1:0]   isr_d;
    logic               int_d;
    logic [31:0]        vec_d;

    assign req = pend & ~mask;

    // Scan downwards so the lowest index (highest priority) is the last one written.
    always_comb begin
        cand_hit = 1'b0;
        cand_idx = '0;
        isr_hit  = 1'b0;
        isr_idx  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                cand_hit = 1'b1;
                cand_idx = IDX_W'(i);
            end
            if (isr[i]) begin
                isr_hit = 1'b1;
                isr_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (NEST_EN)
            eligible = cand_hit && (!isr_hit || (cand_idx < isr_idx));
        else
            eligible = cand_hit && !isr_hit;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (eligible) state_d = REQ;
            REQ: begin
                if (!eligible)     state_d = IDLE;
                else if (INTA_irq) state_d = SERV;
            end
            SERV:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ack    = (state == REQ) && eligible && INTA_irq;
    assign ack_oh = ack ? (N_SRC'(1) << cand_idx) : '0;
    // Lowest set bit of isr: the highest-priority level currently in service.
    assign eoi_clr = eoi ? (isr & (~isr + N_SRC'(1))) : '0;

    // A fresh edge on the acknowledged source survives the acknowledge clear.
    assign pend_edge = (pend & ~ack_oh) | (irq_src & ~hist);
    assign pend_d    = (pend_edge & EDGE_MASK) | (irq_src & ~EDGE_MASK);
    assign isr_d     = (isr & ~eoi_clr) | ack_oh;
    assign int_d     = (state == REQ) && (state_d == REQ);
    assign vec_d     = VEC_BASE + (32'(cand_idx) * 32'(VEC_STRIDE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask      <= '1;
            hist      <= '0;
            pend      <= '0;
            isr       <= '0;
            INT_irq   <= 1'b0;
            vector    <= VEC_BASE;
            vec_valid <= 1'b0;
        end else begin
            state     <= state_d;
            hist      <= irq_src;
            pend      <= pend_d;
            isr       <= isr_d;
            INT_irq   <= int_d;
            vec_valid <= ack;
            if (mask_we) mask   <= mask_wdata;
            if (ack)     vector <= vec_d;
        end
    end

endmodule

// File: tb/tb_irq_vec_ctrl.sv
// Bench for irq_vec_ctrl: per-cycle stimulus/expectation table run through a scoreboard
// queue, followed by a hand-written asynchronous-reset sequence.
module tb_irq_vec_ctrl;

    localparam logic [4:0] CI  = 5'b10000;
    localparam logic [4:0] CV  = 5'b01000;
    localparam logic [4:0] CX  = 5'b00100;
    localparam logic [4:0] CP  = 5'b00010;
    localparam logic [4:0] CS  = 5'b00001;
    localparam logic [4:0] CIV = 5'b11000;
    localparam logic [4:0] ALL = 5'b11111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        mask_we = 1'b0;
    logic [7:0]  mask_wdata = '0;
    logic        INTA_irq = 1'b0;
    logic        eoi = 1'b0;
    logic        INT_irq;
    logic [31:0] vector;
    logic        vec_valid;
    logic [7:0]  pend;
    logic [7:0]  isr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        r;
        logic [7:0]  src;
        logic        we;
        logic [7:0]  wd;
        logic        a;
        logic        e;
        logic [4:0]  care;
        logic        e_int;
        logic        e_vv;
        logic [31:0] e_vec;
        logic [7:0]  e_pend;
        logic [7:0]  e_isr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    irq_vec_ctrl #(
        .N_SRC(8), .EDGE_MASK(8'hFE), .NEST_EN(1'b1),
        .VEC_BASE(32'h0000_0018), .VEC_STRIDE(4)
    ) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .INTA_irq(INTA_irq), .eoi(eoi),
        .INT_irq(INT_irq), .vector(vector), .vec_valid(vec_valid),
        .pend(pend), .isr(isr)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] s, input logic w, input logic [7:0] wd,
                       input logic a, input logic e, input logic [4:0] c, input logic ei,
                       input logic ev, input logic [31:0] evec, input logic [7:0] ep,
                       input logic [7:0] eisr);
        vec_t v;
        v.r = r; v.src = s; v.we = w; v.wd = wd; v.a = a; v.e = e; v.care = c;
        v.e_int = ei; v.e_vv = ev; v.e_vec = evec; v.e_pend = ep; v.e_isr = eisr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        vec_t x;
        // reset and basic edge path on source 3
        add(1, 8'h00, 0, 8'h00, 0, 0, ALL,     0, 0, 32'h18, 8'h00, 8'h00);
        add(0, 8'h00, 1, 8'h00, 0, 0, ALL,     0, 0, 32'h18, 8'h00, 8'h00);
        add(0, 8'h08, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h24, 8'h00, 8'h08);
        add(0, 8'h00, 0, 8'h00, 1, 0, CIV|CS,  0, 0, 0, 0, 8'h08);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        // higher-priority arrival while in REQ
        add(0, 8'h20, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h20, 0);
        add(0, 8'h20, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h22, 0, 8'h00, 0, 0, CIV|CP,  1, 0, 0, 8'h22, 0);
        add(0, 8'h22, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h1C, 8'h20, 8'h02);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h2C, 8'h00, 8'h20);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        // nesting: source 4 in service, source 2 preempts, source 6 waits
        add(0, 8'h10, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h10, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h28, 8'h00, 8'h10);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h04, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h04, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h20, 8'h00, 8'h14);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h10);
        add(0, 8'h40, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h40, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h40, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h30, 8'h00, 8'h40);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        // level source 0: dropped before ack, then held through ack and eoi
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h01, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV|CP,  1, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h01, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h18, 8'h01, 8'h01);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h18, 8'h00, 8'h01);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        // masking in REQ, unmask, edge coinciding with the acknowledge clear
        add(0, 8'h08, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 1, 8'h08, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 1, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV|CP,  1, 0, 0, 8'h08, 0);
        add(0, 8'h08, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h24, 8'h08, 8'h08);
        add(0, 8'h08, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h24, 8'h00, 8'h08);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 1, CIV|CS,  0, 0, 0, 0, 8'h00);
        // same-cycle eoi and nested ack, then reset while in SERV
        add(0, 8'h02, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h02, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, ALL,     0, 1, 32'h1C, 8'h00, 8'h02);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h01, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, CIV,     1, 0, 0, 0, 0);
        add(0, 8'h01, 0, 8'h00, 1, 1, ALL,     0, 1, 32'h18, 8'h01, 8'h01);
        add(1, 8'h01, 0, 8'h00, 0, 0, ALL,     0, 0, 32'h18, 8'h00, 8'h00);
        add(0, 8'h00, 0, 8'h00, 0, 0, ALL,     0, 0, 32'h18, 8'h00, 8'h00);
        // mask is all ones again after reset
        add(0, 8'h08, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV,     0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, CIV|CP,  0, 0, 0, 8'h08, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst        = tbl[k].r;
            irq_src    = tbl[k].src;
            mask_we    = tbl[k].we;
            mask_wdata = tbl[k].wd;
            INTA_irq   = tbl[k].a;
            eoi        = tbl[k].e;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            if (x.care[4]) chk("int_irq",   k, 32'(INT_irq),   32'(x.e_int));
            if (x.care[3]) chk("vec_valid", k, 32'(vec_valid), 32'(x.e_vv));
            if (x.care[2]) chk("vector",    k, vector,         x.e_vec);
            if (x.care[1]) chk("pend",      k, 32'(pend),      32'(x.e_pend));
            if (x.care[0]) chk("isr",       k, 32'(isr),       32'(x.e_isr));
        end

        // Asynchronous reset while a request is being presented, checked between edges.
        @(negedge clk);
        irq_src = 8'h00; mask_we = 1'b1; mask_wdata = 8'h00; INTA_irq = 1'b0; eoi = 1'b0;
        @(negedge clk);
        mask_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("async_pre_int", 1000, 32'(INT_irq), 32'd1);
        chk("async_pre_pend", 1000, 32'(pend), 32'h08);
        rst = 1'b1;
        #1;
        chk("async_int",  1001, 32'(INT_irq), 32'd0);
        chk("async_pend", 1001, 32'(pend),    32'h00);
        chk("async_vec",  1001, vector,       32'h18);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_int", 1002, 32'(INT_irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
